axi_mem_responder: RTL

- AXI4 slave (responder) terminating the system-level AXI master port that the core/vector complex drives through the system mux; the opposite end of that master interface.
- Converts AXI4 read/write bursts into accesses on a single-port SRAM with 1-cycle read latency.
- Used as the bench/FPGA main-memory model and as the on-chip scratchpad behind the mux.
- One transaction in flight at a time; reads and writes arbitrated round-robin.

---
 rtl/axi_mem_responder.sv | 324 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 slave serving one burst at a time from a single-port SRAM with one-cycle read latency.
// The ariane_axi package below supplies the default request/response struct types.

package ariane_axi;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned UserWidth = 1;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
        logic [UserWidth-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_mem_responder #(
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned MemAddrWidth = 16,
    parameter type         axi_req_t    = ariane_axi::req_t,
    parameter type         axi_rsp_t    = ariane_axi::resp_t
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  axi_req_t                    axi_req_i,
    output axi_rsp_t                    axi_resp_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [MemAddrWidth-1:0]     mem_addr_o,
    output logic [AxiDataWidth-1:0]     mem_wdata_o,
    output logic [AxiDataWidth/8-1:0]   mem_be_o,
    input  logic [AxiDataWidth-1:0]     mem_rdata_i
);
    localparam int unsigned StrbWidth = AxiDataWidth / 8;
    localparam int unsigned Off       = $clog2(StrbWidth);
    localparam logic [2:0]  MaxSize   = 3'(Off);
    localparam logic [1:0]  BurstFixed = 2'b00;
    localparam logic [1:0]  BurstIncr  = 2'b01;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        RD_RESP = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5
    } state_e;

    // WRAP, the reserved encoding and beats wider than the bus are refused.
    function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
        burst_err = ((burst != BurstFixed) && (burst != BurstIncr)) || (size > MaxSize);
    endfunction

    // INCR aligns down to the beat size before stepping, so only the first beat may be unaligned.
    function automatic logic [AxiAddrWidth-1:0] next_addr(input logic [AxiAddrWidth-1:0] addr,
                                                          input logic [2:0]              size,
                                                          input logic [1:0]              burst);
        logic [AxiAddrWidth-1:0] bytes;
        bytes = {{(AxiAddrWidth-1){1'b0}}, 1'b1} << size;
        if (burst == BurstFixed) begin
            next_addr = addr;
        end else begin
            next_addr = (addr & ~(bytes - {{(AxiAddrWidth-1){1'b0}}, 1'b1})) + bytes;
        end
    endfunction

    state_e                    state_r;
    logic                      prio_rd_r;
    logic [AxiAddrWidth-1:0]   addr_r;
    logic [7:0]                len_r;
    logic [2:0]                size_r;
    logic [1:0]                burst_r;
    logic [AxiIdWidth-1:0]     id_r;
    logic [8:0]                beat_r;
    logic                      err_r;
    logic                      r_valid_r;
    logic [AxiDataWidth-1:0]   r_data_r;
    logic [1:0]                r_resp_r;
    logic                      r_last_r;
    logic                      b_valid_r;
    logic [1:0]                b_resp_r;

    logic aw_win_s;
    logic ar_win_s;
    logic w_ready_s;
    logic w_hs_s;
    logic beat_is_len_s;
    logic beat_over_s;
    logic wr_mismatch_s;
    logic unused_req_s;

    assign unused_req_s  = ^axi_req_i;
    assign w_ready_s     = rst_ni && (state_r == WR_DATA);
    assign w_hs_s        = w_ready_s && axi_req_i.w_valid;
    assign beat_is_len_s = (beat_r == {1'b0, len_r});
    assign beat_over_s   = (beat_r > {1'b0, len_r});
    assign wr_mismatch_s = (axi_req_i.w.last != beat_is_len_s);

    // Round-robin arbitration between AW and AR while idle; a lone valid always wins.
    always_comb begin
        aw_win_s = 1'b0;
        ar_win_s = 1'b0;
        if (rst_ni && (state_r == IDLE)) begin
            if (axi_req_i.aw_valid && axi_req_i.ar_valid) begin
                aw_win_s = !prio_rd_r;
                ar_win_s = prio_rd_r;
            end else begin
                aw_win_s = axi_req_i.aw_valid;
                ar_win_s = axi_req_i.ar_valid;
            end
        end else begin
            aw_win_s = 1'b0;
            ar_win_s = 1'b0;
        end
    end

    // SRAM strobe: reads from RD_REQ, writes directly off the W handshake.
    always_comb begin
        mem_req_o = 1'b0;
        if (state_r == RD_REQ) begin
            mem_req_o = rst_ni && !err_r;
        end else if (state_r == WR_DATA) begin
            mem_req_o = w_hs_s && !err_r && !beat_over_s;
        end else begin
            mem_req_o = 1'b0;
        end
    end

    assign mem_we_o    = (state_r == WR_DATA);
    assign mem_addr_o  = addr_r[Off +: MemAddrWidth];
    assign mem_wdata_o = axi_req_i.w.data;
    assign mem_be_o    = axi_req_i.w.strb;

    // Response struct assembly; everything except the readies comes from registers.
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_win_s;
        axi_resp_o.ar_ready = ar_win_s;
        axi_resp_o.w_ready  = w_ready_s;
        axi_resp_o.b_valid  = b_valid_r;
        axi_resp_o.b.id     = id_r;
        axi_resp_o.b.resp   = b_resp_r;
        axi_resp_o.r_valid  = r_valid_r;
        axi_resp_o.r.id     = id_r;
        axi_resp_o.r.data   = r_data_r;
        axi_resp_o.r.resp   = r_resp_r;
        axi_resp_o.r.last   = r_last_r;
    end

    // Transaction FSM with burst bookkeeping and registered R/B channels.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            prio_rd_r <= 1'b0;
            addr_r    <= '0;
            len_r     <= 8'd0;
            size_r    <= 3'd0;
            burst_r   <= 2'b00;
            id_r      <= '0;
            beat_r    <= 9'd0;
            err_r     <= 1'b0;
            r_valid_r <= 1'b0;
            r_data_r  <= '0;
            r_resp_r  <= 2'b00;
            r_last_r  <= 1'b0;
            b_valid_r <= 1'b0;
            b_resp_r  <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ar_win_s) begin
                        addr_r    <= axi_req_i.ar.addr;
                        len_r     <= axi_req_i.ar.len;
                        size_r    <= axi_req_i.ar.size;
                        burst_r   <= axi_req_i.ar.burst;
                        id_r      <= axi_req_i.ar.id;
                        err_r     <= burst_err(axi_req_i.ar.burst, axi_req_i.ar.size);
                        beat_r    <= 9'd0;
                        prio_rd_r <= 1'b0;
                        state_r   <= RD_REQ;
                    end else if (aw_win_s) begin
                        addr_r    <= axi_req_i.aw.addr;
                        len_r     <= axi_req_i.aw.len;
                        size_r    <= axi_req_i.aw.size;
                        burst_r   <= axi_req_i.aw.burst;
                        id_r      <= axi_req_i.aw.id;
                        err_r     <= burst_err(axi_req_i.aw.burst, axi_req_i.aw.size);
                        beat_r    <= 9'd0;
                        prio_rd_r <= 1'b1;
                        state_r   <= WR_DATA;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_REQ: begin
                    state_r <= RD_WAIT;
                end
                RD_WAIT: begin
                    r_data_r  <= err_r ? '0 : mem_rdata_i;
                    r_resp_r  <= err_r ? RespSlvErr : RespOkay;
                    r_last_r  <= beat_is_len_s;
                    r_valid_r <= 1'b1;
                    state_r   <= RD_RESP;
                end
                RD_RESP: begin
                    if (axi_req_i.r_ready) begin
                        r_valid_r <= 1'b0;
                        if (r_last_r) begin
                            state_r <= IDLE;
                        end else begin
                            beat_r  <= beat_r + 9'd1;
                            addr_r  <= next_addr(addr_r, size_r, burst_r);
                            state_r <= RD_REQ;
                        end
                    end else begin
                        state_r <= RD_RESP;
                    end
                end
                WR_DATA: begin
                    if (w_hs_s) begin
                        // Saturate so an over-long burst can never wrap back into range.
                        if (beat_r != 9'h1FF) begin
                            beat_r <= beat_r + 9'd1;
                        end else begin
                            beat_r <= beat_r;
                        end
                        addr_r <= next_addr(addr_r, size_r, burst_r);
                        err_r  <= err_r || wr_mismatch_s;
                        if (axi_req_i.w.last) begin
                            b_resp_r  <= (err_r || wr_mismatch_s) ? RespSlvErr : RespOkay;
                            b_valid_r <= 1'b1;
                            state_r   <= WR_RESP;
                        end else begin
                            state_r <= WR_DATA;
                        end
                    end else begin
                        state_r <= WR_DATA;
                    end
                end
                WR_RESP: begin
                    if (axi_req_i.b_ready) begin
                        b_valid_r <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= WR_RESP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule
